// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory channel arbiter.
// Holds the per-channel FSM state type and a round-robin wrap helper.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_BITS     = 8;
  localparam int unsigned DEF_DATA_BITS     = 8;
  localparam int unsigned DEF_NUM_CONSUMERS = 8;
  localparam int unsigned DEF_NUM_CHANNELS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_READ_WAIT   = 3'd1,
    ST_WRITE_WAIT  = 3'd2,
    ST_READ_RELAY  = 3'd3,
    ST_WRITE_RELAY = 3'd4
  } ch_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Masked round-robin find-first: scans eligible requests starting at ptr_i,
// wrapping around, and returns a one-hot grant plus a found flag.
module rr_picker #(
  parameter int unsigned N        = 8,
  parameter int unsigned PTR_BITS = 3
) (
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0]        mask_i,
  input  logic [PTR_BITS-1:0] ptr_i,
  output logic [N-1:0]        grant_o,
  output logic                found_o
);

  logic [N-1:0] elig;
  assign elig = req_i & ~mask_i;

  always_comb begin
    logic [PTR_BITS-1:0] idx;
    grant_o = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PTR_BITS'((32'(ptr_i) + off) % N);
      if (!found_o && elig[idx]) begin
        grant_o[idx] = 1'b1;
        found_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Maps NUM_CONSUMERS LSU read/write requesters onto NUM_CHANNELS memory
// channels, one FSM and one round-robin picker per channel.
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter int unsigned NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int unsigned NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int unsigned CB = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  ch_state_e     state_q [NUM_CHANNELS];
  ch_state_e     state_d [NUM_CHANNELS];
  logic [CB-1:0] ptr_q   [NUM_CHANNELS];
  logic [CB-1:0] ptr_d   [NUM_CHANNELS];
  logic [CB-1:0] cons_q  [NUM_CHANNELS];
  logic [CB-1:0] cons_d  [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] claim_q, claim_d;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0] wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

  logic [NUM_CHANNELS-1:0]                mrv_q, mrv_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mra_q, mra_d;
  logic [NUM_CHANNELS-1:0]                mwv_q, mwv_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mwa_q, mwa_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mwd_q, mwd_d;

  logic [NUM_CONSUMERS-1:0] wr_req, any_req;
  logic [NUM_CONSUMERS-1:0] pick_req   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] pick_mask  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] pick_grant [NUM_CHANNELS];
  logic                     pick_found [NUM_CHANNELS];

  assign wr_req  = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
  assign any_req = consumer_read_valid | wr_req;

  // Each channel's mask includes this cycle's grants of all lower channels.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign pick_req[c] = (state_q[c] == ST_IDLE) ? any_req : '0;
    if (c == 0) begin : g_first
      assign pick_mask[c] = claim_q;
    end else begin : g_rest
      assign pick_mask[c] = pick_mask[c-1] | pick_grant[c-1];
    end
    rr_picker #(
      .N        (NUM_CONSUMERS),
      .PTR_BITS (CB)
    ) u_picker (
      .req_i   (pick_req[c]),
      .mask_i  (pick_mask[c]),
      .ptr_i   (ptr_q[c]),
      .grant_o (pick_grant[c]),
      .found_o (pick_found[c])
    );
  end

  always_comb begin
    logic [CB-1:0] gidx;
    gidx       = '0;
    state_d    = state_q;
    ptr_d      = ptr_q;
    cons_d     = cons_q;
    claim_d    = claim_q;
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rd_data_d  = rd_data_q;
    mrv_d      = mrv_q;
    mra_d      = mra_q;
    mwv_d      = mwv_q;
    mwa_d      = mwa_q;
    mwd_d      = mwd_q;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      gidx = '0;
      case (state_q[c])
        ST_IDLE: begin
          if (pick_found[c]) begin
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
              if (pick_grant[c][i]) begin
                gidx     = CB'(i);
                ptr_d[c] = CB'(rr_next(i, NUM_CONSUMERS));
              end
            end
            cons_d[c]     = gidx;
            claim_d[gidx] = 1'b1;
            if (consumer_read_valid[gidx]) begin
              mrv_d[c]   = 1'b1;
              mra_d[c]   = consumer_read_address[gidx];
              state_d[c] = ST_READ_WAIT;
            end else begin
              mwv_d[c]   = 1'b1;
              mwa_d[c]   = consumer_write_address[gidx];
              mwd_d[c]   = consumer_write_data[gidx];
              state_d[c] = ST_WRITE_WAIT;
            end
          end
        end
        ST_READ_WAIT: begin
          if (mem_read_ready[c]) begin
            mrv_d[c]              = 1'b0;
            rd_data_d[cons_q[c]]  = mem_read_data[c];
            rd_ready_d[cons_q[c]] = 1'b1;
            state_d[c]            = ST_READ_RELAY;
          end
        end
        ST_WRITE_WAIT: begin
          if (mem_write_ready[c]) begin
            mwv_d[c]              = 1'b0;
            wr_ready_d[cons_q[c]] = 1'b1;
            state_d[c]            = ST_WRITE_RELAY;
          end
        end
        ST_READ_RELAY: begin
          if (!consumer_read_valid[cons_q[c]]) begin
            rd_ready_d[cons_q[c]] = 1'b0;
            claim_d[cons_q[c]]    = 1'b0;
            state_d[c]            = ST_IDLE;
          end
        end
        ST_WRITE_RELAY: begin
          if (!consumer_write_valid[cons_q[c]]) begin
            wr_ready_d[cons_q[c]] = 1'b0;
            claim_d[cons_q[c]]    = 1'b0;
            state_d[c]            = ST_IDLE;
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        ptr_q[c]   <= '0;
        cons_q[c]  <= '0;
      end
      claim_q    <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      mrv_q      <= '0;
      mra_q      <= '0;
      mwv_q      <= '0;
      mwa_q      <= '0;
      mwd_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cons_q     <= cons_d;
      claim_q    <= claim_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
      mrv_q      <= mrv_d;
      mra_q      <= mra_d;
      mwv_q      <= mwv_d;
      mwa_q      <= mwa_d;
      mwd_q      <= mwd_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_read_data   = rd_data_q;
  assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_q : '0;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = (WRITE_ENABLE != 0) ? mwv_q : '0;
  assign mem_write_address    = (WRITE_ENABLE != 0) ? mwa_q : '0;
  assign mem_write_data       = (WRITE_ENABLE != 0) ? mwd_q : '0;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: 4-channel instance for read/write/stall/reset cases and a
// 1-channel instance for round-robin alternation.
module tb_mem_channel_arbiter;

  logic clk;
  logic reset;

  // 4-channel instance
  logic [7:0]      a_rv, a_crr, a_wv, a_cwr;
  logic [7:0][7:0] a_ra, a_crd, a_wa, a_wd;
  logic [3:0]      a_mrv, a_mrr, a_mwv, a_mwr;
  logic [3:0][7:0] a_mra, a_mrd, a_mwa, a_mwd;

  // 1-channel instance
  logic [7:0]      b_rv, b_crr, b_wv, b_cwr, b_rereq;
  logic [7:0][7:0] b_ra, b_crd, b_wa, b_wd;
  logic [0:0]      b_mrv, b_mrr, b_mwv, b_mwr;
  logic [0:0][7:0] b_mra, b_mrd, b_mwa, b_mwd;

  logic [7:0] mem    [256];
  int         wr_cnt [256];
  logic       rd_en;

  int n_checks;
  int n_fail;

  mem_channel_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4), .WRITE_ENABLE(1)
  ) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
    .consumer_write_data(a_wd), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_channel_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1), .WRITE_ENABLE(1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reads answer in the same cycle the request is seen.
  always_comb begin
    a_mrr = a_mrv & {4{rd_en}};
    a_mwr = a_mwv;
    for (int c = 0; c < 4; c++) a_mrd[c] = mem[a_mra[c]];
    b_mrr = b_mrv;
    b_mrd = '0;
    b_mwr = b_mwv;
  end

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (a_mwv[c] && a_mwr[c]) begin
        mem[a_mwa[c]]    = a_mwd[c];
        wr_cnt[a_mwa[c]] = wr_cnt[a_mwa[c]] + 1;
      end
    end
  end

  // Consumers drop valid once they see ready; dut_b consumers re-request.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 8; i++) begin
      if (a_crr[i]) a_rv[i] = 1'b0;
      if (a_cwr[i]) a_wv[i] = 1'b0;
      if (b_crr[i]) b_rv[i] = 1'b0;
      else if (b_rereq[i] && !b_rv[i]) b_rv[i] = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_a_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = (a_crr == 8'h0) && (a_cwr == 8'h0) && (a_rv == 8'h0) && (a_wv == 8'h0);
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_idle_mv"}, {a_mrv, a_mwv}, 64'h0);
  endtask

  initial begin
    logic [7:0] grants [4];
    int         n_g;
    logic       prev;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rd_en    = 1'b1;
    a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0;
    b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0; b_rereq = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'h00;
      wr_cnt[i] = 0;
    end
    mem[8'h10] = 8'hA5;
    mem[8'h33] = 8'h5C;
    mem[8'h44] = 8'h3C;

    #1 reset = 1'b0;
    #1;
    check("rst_mrv", a_mrv, 64'h0);
    check("rst_mwv", a_mwv, 64'h0);
    check("rst_crr", {a_crr, a_cwr}, 64'h0);
    check("rst_crd", a_crd, 64'h0);
    check("rst_mra", {a_mra, a_mwa}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single read, 1-cycle memory
    @(negedge clk);
    a_ra[0] = 8'h10;
    a_rv[0] = 1'b1;
    @(negedge clk);
    check("rd_grant_mrv", a_mrv, 64'h1);
    check("rd_grant_mra", a_mra[0], 64'h10);
    check("rd_grant_crr", a_crr, 64'h0);
    @(negedge clk);
    check("rd_done_mrv", a_mrv, 64'h0);
    check("rd_done_crr", a_crr, 64'h1);
    check("rd_done_crd", a_crd[0], 64'hA5);
    @(negedge clk);
    check("rd_relay_crr", a_crr, 64'h0);
    check("rd_hold_crd", a_crd[0], 64'hA5);
    wait_a_idle("rd");

    // Stall: memory withholds read ready for 10 cycles
    rd_en   = 1'b0;
    a_ra[2] = 8'h33;
    a_rv[2] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("stall_mrv", a_mrv, 64'h1);
      check("stall_mra", a_mra[0], 64'h33);
      check("stall_crr", a_crr, 64'h0);
      @(negedge clk);
    end
    rd_en = 1'b1;
    @(negedge clk);
    check("stall_done_crr", a_crr, 64'h04);
    check("stall_done_crd", a_crd[2], 64'h5C);
    wait_a_idle("stall");

    // Reset pulse so pointers start at 0, then 8 simultaneous writes
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_wa[i] = 8'(i);
      a_wd[i] = 8'(i + 1);
    end
    a_wv = 8'hFF;
    @(negedge clk);
    check("wr1_mwv", a_mwv, 64'hF);
    check("wr1_mwa", a_mwa, 64'h03020100);
    check("wr1_mwd", a_mwd, 64'h04030201);
    @(negedge clk);
    check("wr1_cwr", a_cwr, 64'h0F);
    check("wr1_mwv_drop", a_mwv, 64'h0);
    @(negedge clk);
    check("wr_relay_mwv", a_mwv, 64'h0);
    @(negedge clk);
    check("wr2_mwv", a_mwv, 64'hF);
    check("wr2_mwa", a_mwa, 64'h07060504);
    check("wr2_mwd", a_mwd, 64'h08070605);
    wait_a_idle("wr");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wr_mem%0d", i), mem[i], 64'(i + 1));
      check($sformatf("wr_cnt%0d", i), 64'(wr_cnt[i]), 64'd1);
    end

    // Reset while a read waits on memory; pointer wrap picks consumer 1
    rd_en   = 1'b0;
    a_ra[1] = 8'h44;
    a_rv[1] = 1'b1;
    @(negedge clk);
    check("rw_mrv", a_mrv, 64'h1);
    check("rw_mra", a_mra[0], 64'h44);
    reset = 1'b0;
    #1;
    check("rw_rst_mv", {a_mrv, a_mwv}, 64'h0);
    check("rw_rst_rdy", {a_crr, a_cwr}, 64'h0);
    check("rw_rst_crd", a_crd, 64'h0);
    check("rw_rst_addr", {a_mra, a_mwa}, 64'h0);
    @(negedge clk);
    check("rw_hold_crr", a_crr, 64'h0);
    rd_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rw_again_mrv", a_mrv, 64'h1);
    check("rw_again_mra", a_mra[0], 64'h44);
    @(negedge clk);
    check("rw_again_crr", a_crr, 64'h02);
    check("rw_again_crd", a_crd[1], 64'h3C);
    wait_a_idle("rw");

    // Fairness on a single channel
    b_ra[0] = 8'h20;
    b_ra[1] = 8'h21;
    b_rereq = 8'h03;
    n_g     = 0;
    prev    = 1'b0;
    for (int k = 0; k < 200 && n_g < 4; k++) begin
      @(negedge clk);
      if (b_mrv[0] && !prev) begin
        grants[n_g] = b_mra[0];
        n_g++;
      end
      prev = b_mrv[0];
    end
    b_rereq = 8'h00;
    check("rr_count", 64'(n_g), 64'd4);
    for (int g = 0; g < n_g; g++)
      check($sformatf("rr_grant%0d", g), grants[g], (g % 2 == 0) ? 64'h20 : 64'h21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_channel_arbiter.md
MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, 8, address width.
REQ-002 SHALL have parameter DATA_BITS, 8, data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, 8, LSU requesters (2 cores x 4 threads max).
REQ-004 SHALL have parameter NUM_CHANNELS, 4, memory channels, 1 <= NUM_CHANNELS <= NUM_CONSUMERS.
REQ-005 SHALL have parameter WRITE_ENABLE, 1, 0 removes the write path and ties write outputs to 0.
REQ-006 SHALL have port clk  in  1  the only clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port consumer_read_valid  in  [NUM_CONSUMERS]  read request held until ready.
REQ-009 SHALL have port consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address.
REQ-010 SHALL have port consumer_read_ready  out  [NUM_CONSUMERS]  read done, data valid.
REQ-011 SHALL have port consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned data.
REQ-012 SHALL have port consumer_write_valid  in  [NUM_CONSUMERS]  write request held until ready.
REQ-013 SHALL have port consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address.
REQ-014 SHALL have port consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data.
REQ-015 SHALL have port consumer_write_ready  out  [NUM_CONSUMERS]  write done.
REQ-016 SHALL have port mem_read_valid  out  [NUM_CHANNELS]  channel read request.
REQ-017 SHALL have port mem_read_address  out  [NUM_CHANNELS][ADDR_BITS]  channel read address.
REQ-018 SHALL have port mem_read_ready  in  [NUM_CHANNELS]  memory read done.
REQ-019 SHALL have port mem_read_data  in  [NUM_CHANNELS][DATA_BITS]  memory read data.
REQ-020 SHALL have ports mem_write_valid/address/data out and mem_write_ready in, with widths matching the read side.

Function
REQ-021 SHALL run one FSM per channel with states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
REQ-022 In IDLE, a channel SHALL pick an unclaimed consumer with valid set, round-robin from its last grant + 1; read beats write for the same consumer.
REQ-023 Same-cycle grants SHALL go in channel-index order; a lower channel's claim masks that consumer from higher channels in that cycle, so no consumer is granted twice.
REQ-024 On grant at edge t, the channel SHALL drive mem_*_valid plus address/data (data on writes only) from edge t, and set the consumer's claim bit.
REQ-025 In *_WAIT, a channel SHALL hold mem valid and address stable until mem_*_ready is sampled high, then drop mem valid at that edge.
REQ-026 At that edge it SHALL latch mem_read_data, assert consumer_*_ready and move to *_RELAY: consumer ready follows mem ready by one cycle.
REQ-027 In *_RELAY, consumer ready SHALL stay high until the consumer's valid is sampled low, then drop ready, clear the claim bit and return to IDLE.
REQ-028 consumer_read_data SHALL hold its value until that consumer's next read completes.
REQ-029 Best-case occupancy SHALL be 3 cycles per access for 1-cycle memory: grant, mem ready, valid low.
REQ-030 With no pending requests, all mem_* valid outputs SHALL be 0.
REQ-031 With all channels busy, new requests SHALL wait unbounded; round-robin SHALL serve each valid consumer within NUM_CONSUMERS grants of that channel.
REQ-032 Round-robin pointers SHALL wrap from NUM_CONSUMERS-1 to 0.

Reset
REQ-033 Reset low SHALL immediately force all FSMs to IDLE, clear claim bits and round-robin pointers to 0, and drive every valid/ready output and all data outputs to 0.
REQ-034 Reset mid-transaction SHALL abandon in-flight accesses without issuing a consumer ready.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the channel state enum and default width constants.
REQ-036 Sub-module rr_picker SHALL do the masked round-robin find-first (request vector, mask, pointer -> one-hot grant, found flag); one instance per channel.

Verification
REQ-037 Single read: consumer 0 reads addr 0x10, memory holds 0xA5, 1-cycle ready -> mem_read_valid[0] is high 1 cycle, consumer_read_ready[0] rises the cycle after mem ready, and consumer_read_data[0]=0xA5.
REQ-038 Eight consumers write addr i with data i+1 in the same cycle, 4 channels -> channels 0..3 take consumers 0..3, then 4..7; memory holds 1..8; no consumer is granted twice.
REQ-039 Fairness: consumers 0 and 1 re-request continuously, NUM_CHANNELS=1 -> grants alternate 0,1,0,1.
REQ-040 Stall: mem_read_ready held low 10 cycles -> mem valid and address stay stable, and consumer ready stays 0 throughout.
REQ-041 Reset low during READ_WAIT -> all outputs 0 immediately; after release, a fresh read completes normally.
